// File: rtl/rob_if.sv
// Channel bundle between the ROB pipeline stage and its reorder-buffer storage:
// allocate, complete, operand read, retire, plus the global flush.
interface rob_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int EXC_WIDTH  = 3
);
  logic                  flush;
  logic                  rob_write_en;
  logic                  rob_can_write;
  logic [ADDR_WIDTH-1:0] rob_write_addr;
  logic                  rob_write_reg_write_en;
  logic [4:0]            rob_write_reg_write_addr;
  logic [EXC_WIDTH-1:0]  rob_write_exception_type;
  logic                  rob_write_is_delayslot;
  logic [31:0]           rob_write_pc;
  logic                  done_en;
  logic [ADDR_WIDTH-1:0] done_addr;
  logic [31:0]           done_data;
  logic [ADDR_WIDTH-1:0] read_addr;
  logic                  read_done;
  logic [31:0]           read_data;
  logic                  rob_commit_en;
  logic                  rob_can_commit;
  logic                  rob_commit_reg_write_en;
  logic [4:0]            rob_commit_reg_write_addr;
  logic [31:0]           rob_commit_reg_write_data;
  logic [EXC_WIDTH-1:0]  rob_commit_exception_type;
  logic                  rob_commit_is_delayslot;
  logic [31:0]           rob_commit_pc;
  logic [ADDR_WIDTH:0]   rob_count;

  modport master (
    output flush, rob_write_en, rob_write_reg_write_en, rob_write_reg_write_addr,
           rob_write_exception_type, rob_write_is_delayslot, rob_write_pc,
           done_en, done_addr, done_data, read_addr, rob_commit_en,
    input  rob_can_write, rob_write_addr, read_done, read_data, rob_can_commit,
           rob_commit_reg_write_en, rob_commit_reg_write_addr, rob_commit_reg_write_data,
           rob_commit_exception_type, rob_commit_is_delayslot, rob_commit_pc, rob_count
  );

  modport slave (
    input  flush, rob_write_en, rob_write_reg_write_en, rob_write_reg_write_addr,
           rob_write_exception_type, rob_write_is_delayslot, rob_write_pc,
           done_en, done_addr, done_data, read_addr, rob_commit_en,
    output rob_can_write, rob_write_addr, read_done, read_data, rob_can_commit,
           rob_commit_reg_write_en, rob_commit_reg_write_addr, rob_commit_reg_write_data,
           rob_commit_exception_type, rob_commit_is_delayslot, rob_commit_pc, rob_count
  );
endinterface

// File: rtl/rob_buffer.sv
// Circular reorder buffer: in-order allocate, out-of-order complete, in-order
// retire, with a combinational operand read port that bypasses same-cycle completions.
module rob_buffer #(
  parameter int                   ADDR_WIDTH    = 5,
  parameter int                   EXC_WIDTH     = 3,
  parameter logic [EXC_WIDTH-1:0] EXC_TYPE_NULL = '0
) (
  input logic clk,
  input logic rst,
  rob_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] PTR_ONE = 1;

  logic [ADDR_WIDTH:0]   head_reg, tail_reg;
  logic [ADDR_WIDTH-1:0] head_idx, tail_idx;
  logic [DEPTH-1:0]      valid_vec, done_vec;
  logic [31:0]           data_arr [DEPTH];

  logic                  reg_write_en_arr   [DEPTH];
  logic [4:0]            reg_write_addr_arr [DEPTH];
  logic [EXC_WIDTH-1:0]  exception_type_arr [DEPTH];
  logic                  is_delayslot_arr   [DEPTH];
  logic [31:0]           pc_arr             [DEPTH];

  logic full, can_commit, write_fire, done_fire, commit_fire, bypass, read_hit;

  assign head_idx    = head_reg[ADDR_WIDTH-1:0];
  assign tail_idx    = tail_reg[ADDR_WIDTH-1:0];
  assign full        = (head_idx == tail_idx) && (head_reg[ADDR_WIDTH] != tail_reg[ADDR_WIDTH]);
  assign can_commit  = valid_vec[head_idx] && done_vec[head_idx];
  // Fullness is judged on the current pointers, so a same-cycle commit never frees a slot early.
  assign write_fire  = bus.rob_write_en && !full;
  assign done_fire   = bus.done_en && valid_vec[bus.done_addr] && !done_vec[bus.done_addr];
  assign commit_fire = bus.rob_commit_en && can_commit;

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      head_reg <= '0;
      tail_reg <= '0;
    end else begin
      if (write_fire)  tail_reg <= tail_reg + PTR_ONE;
      if (commit_fire) head_reg <= head_reg + PTR_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (write_fire) begin
      reg_write_en_arr[tail_idx]   <= bus.rob_write_reg_write_en;
      reg_write_addr_arr[tail_idx] <= bus.rob_write_reg_write_addr;
      exception_type_arr[tail_idx] <= bus.rob_write_exception_type;
      is_delayslot_arr[tail_idx]   <= bus.rob_write_is_delayslot;
      pc_arr[tail_idx]             <= bus.rob_write_pc;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      localparam logic [ADDR_WIDTH-1:0] ENTRY_IDX = ADDR_WIDTH'(gi);
      logic        valid_reg, done_reg;
      logic [31:0] data_reg;
      logic        alloc_hit, done_hit, commit_hit;

      assign alloc_hit  = write_fire  && (tail_idx == ENTRY_IDX);
      assign done_hit   = done_fire   && (bus.done_addr == ENTRY_IDX);
      assign commit_hit = commit_fire && (head_idx == ENTRY_IDX);

      always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
          valid_reg <= 1'b0;
          done_reg  <= 1'b0;
        end else if (alloc_hit) begin
          // Excepting instructions have nothing to execute; they are ready to retire at once.
          valid_reg <= 1'b1;
          done_reg  <= (bus.rob_write_exception_type != EXC_TYPE_NULL);
        end else if (commit_hit) begin
          valid_reg <= 1'b0;
          done_reg  <= 1'b0;
        end else if (done_hit) begin
          done_reg  <= 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (alloc_hit)     data_reg <= '0;
        else if (done_hit) data_reg <= bus.done_data;
      end

      assign valid_vec[gi] = valid_reg;
      assign done_vec[gi]  = done_reg;
      assign data_arr[gi]  = data_reg;
    end
  endgenerate

  assign bus.rob_can_write  = !full;
  assign bus.rob_write_addr = tail_idx;
  assign bus.rob_count      = tail_reg - head_reg;

  assign bus.rob_can_commit            = can_commit;
  assign bus.rob_commit_reg_write_en   = can_commit && reg_write_en_arr[head_idx];
  assign bus.rob_commit_reg_write_addr = can_commit ? reg_write_addr_arr[head_idx] : '0;
  assign bus.rob_commit_reg_write_data = can_commit ? data_arr[head_idx] : '0;
  assign bus.rob_commit_exception_type = can_commit ? exception_type_arr[head_idx] : EXC_TYPE_NULL;
  assign bus.rob_commit_is_delayslot   = can_commit && is_delayslot_arr[head_idx];
  assign bus.rob_commit_pc             = can_commit ? pc_arr[head_idx] : '0;

  assign bypass        = bus.done_en && (bus.done_addr == bus.read_addr) && valid_vec[bus.read_addr];
  assign read_hit      = valid_vec[bus.read_addr] && done_vec[bus.read_addr];
  assign bus.read_done = bypass || read_hit;
  assign bus.read_data = bypass ? bus.done_data : (read_hit ? data_arr[bus.read_addr] : '0);
endmodule

// File: tb/tb_rob_buffer.sv
// Reorder-buffer bench: directed scenarios then random traffic, all outputs
// compared every cycle against a queue-of-in-flight-instructions model.
module tb_rob_buffer;
  localparam int AW = 5;
  localparam int EW = 3;
  localparam int DEPTH = 32;

  logic clk;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  rob_if #(.ADDR_WIDTH(AW), .EXC_WIDTH(EW)) bus ();

  rob_buffer #(.ADDR_WIDTH(AW), .EXC_WIDTH(EW), .EXC_TYPE_NULL(3'd0)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    bit          done;
    logic [31:0] data;
    logic        rwe;
    logic [4:0]  rwa;
    logic [2:0]  exc;
    logic        ds;
    logic [31:0] pc;
  } ent_t;

  ent_t q[$];
  int   tail_id = 0;

  task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic idle();
    bus.flush = 0; bus.rob_write_en = 0; bus.done_en = 0; bus.rob_commit_en = 0;
    bus.rob_write_reg_write_en = 0; bus.rob_write_reg_write_addr = 0;
    bus.rob_write_exception_type = 0; bus.rob_write_is_delayslot = 0; bus.rob_write_pc = 0;
    bus.done_addr = 0; bus.done_data = 0; bus.read_addr = 0;
  endtask

  task automatic set_write(input logic [31:0] pc, input logic [2:0] exc);
    bus.rob_write_en = 1;
    bus.rob_write_pc = pc;
    bus.rob_write_exception_type = exc;
    bus.rob_write_reg_write_en = pc[2];
    bus.rob_write_reg_write_addr = pc[8:4];
    bus.rob_write_is_delayslot = pc[3];
  endtask

  task automatic set_done(input int id, input logic [31:0] data);
    bus.done_en = 1;
    bus.done_addr = id[AW-1:0];
    bus.done_data = data;
  endtask

  task automatic check_outputs();
    bit cc;
    int k;
    cc = (q.size() > 0) && q[0].done;
    check_value("can_write", bus.rob_can_write, q.size() < DEPTH);
    check_value("write_addr", bus.rob_write_addr, tail_id);
    check_value("count", bus.rob_count, q.size());
    check_value("can_commit", bus.rob_can_commit, cc);
    check_value("commit_rwe", bus.rob_commit_reg_write_en, cc ? q[0].rwe : 1'b0);
    check_value("commit_rwa", bus.rob_commit_reg_write_addr, cc ? q[0].rwa : 5'd0);
    check_value("commit_data", bus.rob_commit_reg_write_data, cc ? q[0].data : 32'd0);
    check_value("commit_exc", bus.rob_commit_exception_type, cc ? q[0].exc : 3'd0);
    check_value("commit_ds", bus.rob_commit_is_delayslot, cc ? q[0].ds : 1'b0);
    check_value("commit_pc", bus.rob_commit_pc, cc ? q[0].pc : 32'd0);
    k = -1;
    foreach (q[i]) if (q[i].id == int'(bus.read_addr)) k = i;
    if (k >= 0 && bus.done_en && bus.done_addr == bus.read_addr) begin
      check_value("read_done", bus.read_done, 1'b1);
      check_value("read_data", bus.read_data, bus.done_data);
    end else begin
      check_value("read_done", bus.read_done, (k >= 0) ? q[k].done : 1'b0);
      check_value("read_data", bus.read_data, (k >= 0 && q[k].done) ? q[k].data : 32'd0);
    end
  endtask

  task automatic update_model();
    bit   full, cc;
    ent_t e;
    if (rst || bus.flush) begin
      q.delete();
      tail_id = 0;
      return;
    end
    full = (q.size() == DEPTH);
    cc = (q.size() > 0) && q[0].done;
    if (bus.done_en)
      foreach (q[i])
        if (q[i].id == int'(bus.done_addr) && !q[i].done) begin
          q[i].done = 1;
          q[i].data = bus.done_data;
        end
    if (bus.rob_commit_en && cc) void'(q.pop_front());
    if (bus.rob_write_en && !full) begin
      e.id = tail_id; e.data = 0;
      e.done = (bus.rob_write_exception_type != 0);
      e.rwe = bus.rob_write_reg_write_en; e.rwa = bus.rob_write_reg_write_addr;
      e.exc = bus.rob_write_exception_type; e.ds = bus.rob_write_is_delayslot;
      e.pc = bus.rob_write_pc;
      q.push_back(e);
      tail_id = (tail_id + 1) % DEPTH;
    end
  endtask

  task automatic step();
    @(negedge clk);
    if (!rst) check_outputs();
    $display("cyc=%0d rst=%0b flush=%0b we=%0b de=%0b da=%0d ce=%0b ra=%0d count=%0d",
             cyc, rst, bus.flush, bus.rob_write_en, bus.done_en, bus.done_addr,
             bus.rob_commit_en, bus.read_addr, bus.rob_count);
    @(posedge clk);
    update_model();
    cyc++;
    #1;
  endtask

  task automatic do_flush();
    idle(); bus.flush = 1; step(); bus.flush = 0;
  endtask

  initial begin
    int id;
    rst = 1; idle(); step(); step(); rst = 0;

    // fill to full, 33rd write refused
    for (int i = 0; i < 33; i++) begin idle(); set_write(32'h1000 + 4 * i, 0); step(); end
    idle(); step();

    // out-of-order completion then in-order retire
    do_flush();
    for (int i = 0; i < 3; i++) begin idle(); set_write(32'h1000 + 4 * i, 0); step(); end
    idle(); set_done(2, 32'hAA); step();
    idle(); set_done(0, 32'hBB); step();
    idle(); step();
    idle(); bus.rob_commit_en = 1; step();
    idle(); step();
    idle(); set_done(1, 32'hCC); step();
    idle(); step();

    // same-cycle read bypass, then stored value
    do_flush();
    for (int i = 0; i < 6; i++) begin idle(); set_write(32'h2000 + 4 * i, 0); step(); end
    idle(); set_done(5, 32'hDEADBEEF); bus.read_addr = 5; step();
    idle(); bus.read_addr = 5; step();

    // full: commit + write same cycle refuses the write, next write wraps
    do_flush();
    for (int i = 0; i < 32; i++) begin idle(); set_write(32'h3000 + 4 * i, 0); step(); end
    idle(); set_done(0, 32'h11); step();
    idle(); bus.rob_commit_en = 1; set_write(32'h4000, 0); step();
    idle(); set_write(32'h4004, 0); step();
    idle(); step();

    // exception entry is immediately committable
    do_flush();
    idle(); set_write(32'h5000, 3'd3); step();
    idle(); step();
    idle(); bus.rob_commit_en = 1; step();

    // flush with concurrent traffic, stale completion afterwards
    do_flush();
    for (int i = 0; i < 10; i++) begin idle(); set_write(32'h6000 + 4 * i, 0); step(); end
    idle(); bus.flush = 1; set_done(3, 32'h33); set_write(32'h7000, 0); step();
    idle(); set_done(3, 32'h44); bus.read_addr = 3; step();
    idle(); bus.read_addr = 3; step();

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      idle();
      if ($urandom_range(99) < 60) set_write($urandom, ($urandom_range(9) == 0) ? 3'($urandom_range(7, 1)) : 3'd0);
      if ($urandom_range(99) < 70) begin
        if (q.size() > 0 && $urandom_range(99) < 80) id = q[$urandom_range(q.size() - 1)].id;
        else id = $urandom_range(DEPTH - 1);
        set_done(id, $urandom);
      end
      bus.rob_commit_en = ($urandom_range(99) < 55);
      bus.read_addr = ($urandom_range(99) < 30) ? bus.done_addr : AW'($urandom_range(DEPTH - 1));
      bus.flush = ($urandom_range(199) == 0);
      rst = ($urandom_range(399) == 0);
      step();
      rst = 0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
